// File: rtl/memory_stage_pkg.sv
// Shared types for the memory stage: FSM state encoding and latched memory-operation codes.
package memory_stage_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        MEM_OP_NONE = 2'd0,
        MEM_OP_RD   = 2'd1,
        MEM_OP_WR   = 2'd2
    } mem_op_t;

    // A memory op is illegal if it is both a load and a store, or if it targets an odd byte.
    function automatic logic bad_mem_op(input logic rd, input logic wr, input logic addr_lsb);
        return (rd & wr) | ((rd | wr) & addr_lsb);
    endfunction

endpackage

// File: rtl/memory_stage_wait_timer.sv
// Wait-cycle counter for an outstanding memory access; flags when the count reaches TIMEOUT.
module wait_timer #(
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = 31
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/memory_stage.sv
// EX/MEM consumer: issues single-cycle strobes to a stallable data memory, stalls upstream
// during the access, and presents registered results to writeback. Handles halt/dump and faults.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 31,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] srcb_in,
    input  logic              memread_in,
    input  logic              memwrt_in,
    input  logic              dmp_in,
    input  logic [1:0]        regsrc_in,
    output logic              stall_out,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_dump,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_stall,
    input  logic              mem_done,
    input  logic              mem_err,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_rdata,
    output logic [DATA_W-1:0] wb_alu,
    output logic [1:0]        wb_regsrc,
    output logic              err_out,
    output logic              halt_out
);

    state_t  state, next_state;
    mem_op_t op_q, op_next;
    logic    is_mem;
    logic    cap_wb, cap_load, dump_next;
    logic    timer_clear, timer_en, expired;

    assign is_mem = memread_in | memwrt_in;

    wait_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (expired)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state  = state;
        op_next     = op_q;
        stall_out   = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        cap_wb      = 1'b0;
        cap_load    = 1'b0;
        dump_next   = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                next_state = S_IDLE;
                if (valid_in) begin
                    if (dmp_in) begin
                        next_state = S_HALT;
                        dump_next  = 1'b1;
                    end else if (is_mem) begin
                        stall_out = 1'b1;
                        if (bad_mem_op(memread_in, memwrt_in, alu_in[0])) begin
                            next_state = S_ERR;
                        end else begin
                            next_state = S_REQ;
                            op_next    = memread_in ? MEM_OP_RD : MEM_OP_WR;
                        end
                    end else begin
                        // Non-memory op: goes straight to DONE for a one-cycle writeback.
                        next_state = S_DONE;
                        cap_wb     = 1'b1;
                    end
                end
            end
            S_REQ: begin
                stall_out = 1'b1;
                mem_addr  = alu_in;
                mem_wdata = (op_q == MEM_OP_WR) ? srcb_in : '0;
                if (!mem_stall) begin
                    mem_rd      = (op_q == MEM_OP_RD);
                    mem_wr      = (op_q == MEM_OP_WR);
                    timer_clear = 1'b1;
                    next_state  = S_WAIT;
                end
            end
            S_WAIT: begin
                stall_out = 1'b1;
                timer_en  = 1'b1;
                if (mem_err) begin
                    next_state = S_ERR;
                end else if (mem_done) begin
                    next_state = S_DONE;
                    cap_wb     = 1'b1;
                    cap_load   = (op_q == MEM_OP_RD);
                end else if (expired) begin
                    next_state = S_ERR;
                end
            end
            S_ERR, S_HALT: begin
                stall_out = 1'b1;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= MEM_OP_NONE;
            mem_dump  <= 1'b0;
            wb_rdata  <= '0;
            wb_alu    <= '0;
            wb_regsrc <= '0;
        end else begin
            state    <= next_state;
            op_q     <= op_next;
            mem_dump <= dump_next;
            if (cap_wb) begin
                wb_alu    <= alu_in;
                wb_regsrc <= regsrc_in;
                wb_rdata  <= cap_load ? mem_rdata : '0;
            end
        end
    end

    assign wb_valid = (state == S_DONE);
    assign err_out  = (state == S_ERR);
    assign halt_out = (state == S_HALT);

endmodule
